// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encoding,
// default acknowledge byte and the byte counts of the length and data fields.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ACK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_t;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hAA;
    localparam int unsigned LEN_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

    // Big-endian accumulation: the earliest byte ends up in bits [31:24].
    function automatic logic [31:0] be_shift(input logic [31:0] acc, input logic [7:0] b);
        return {acc[23:0], b};
    endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Packs a byte stream into 32-bit big-endian words. word_valid_o is a
// combinational pulse in the cycle the final byte is presented.
module uart_word_assembler
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_in_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] shreg_q;

    assign cnt_d        = cnt_q + 2'd1;
    assign word_o       = be_shift(shreg_q, byte_in_i);
    assign word_valid_o = byte_valid_i && (cnt_q == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (!rstn || clr_i) begin
            cnt_q   <= 2'd0;
            shreg_q <= 32'd0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_d;
            shreg_q <= word_o;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: reads a 32-bit word count and that many words from uart_rx,
// writes them to instruction memory from address 0, then sends one ACK byte.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = 15,
    parameter logic [7:0]  ACK_BYTE = ACK_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    input  logic              rx_ferr_i,
    input  logic              tx_busy_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output loader_state_t     state_o
);

    localparam logic [32:0]     N_MAX   = 33'(1) << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t     state_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   wcnt_q;
    logic [ADDR_W:0]   wcnt_d;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              imem_we_q;
    logic [7:0]        tx_data_q;
    logic              tx_start_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic        byte_ok;
    logic [31:0] word;
    logic        word_valid;
    logic        n_too_big;

    // A byte that coincides with a framing error is dropped; the WRITE cycle
    // still accepts bytes so back-to-back words are not lost.
    assign byte_ok = rx_valid_i && !rx_ferr_i &&
                     ((state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_WRITE));

    assign wcnt_d    = wcnt_q + CNT_ONE;
    assign n_too_big = {1'b0, word} > N_MAX;

    uart_word_assembler u_asm (
        .clk          (clk),
        .rstn         (rstn),
        .clr_i        (state_q == ST_IDLE),
        .byte_valid_i (byte_ok),
        .byte_in_i    (rx_data_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            wcnt_q       <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            imem_we_q    <= 1'b0;
            tx_data_q    <= 8'd0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_we_q  <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q     <= ST_LEN;
                        busy_q      <= 1'b1;
                        n_q         <= '0;
                        wcnt_q      <= '0;
                        imem_addr_q <= '0;
                    end
                end
                ST_LEN: begin
                    if (rx_ferr_i) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (word_valid) begin
                        n_q <= word[ADDR_W:0];
                        if (n_too_big) begin
                            state_q <= ST_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else if (word == 32'd0) begin
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_ferr_i) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (word_valid) begin
                        state_q      <= ST_WRITE;
                        imem_we_q    <= 1'b1;
                        imem_wdata_q <= word;
                        imem_addr_q  <= wcnt_q[ADDR_W-1:0];
                    end
                end
                // The address register keeps the last written index, so it
                // never wraps even when N fills the whole memory.
                ST_WRITE: begin
                    wcnt_q  <= wcnt_d;
                    state_q <= (wcnt_d == n_q) ? ST_ACK : ST_DATA;
                end
                ST_ACK: begin
                    if (tx_start_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (!tx_busy_i) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= ACK_BYTE;
                    end
                end
                ST_DONE: state_q <= ST_DONE;
                ST_ERR:  state_q <= ST_ERR;
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_start_o   = tx_start_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: one instance at ADDR_W=15 and one at
// ADDR_W=4, selected by sel; writes and ACK bytes are scoreboarded.
module tb_uart_loader;
    import uart_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sel = 1'b0;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_ferr = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_data = 8'd0;

    always #5 clk = ~clk;

    logic [7:0]  a_tx_data, b_tx_data;
    logic        a_tx_start, b_tx_start, a_we, b_we;
    logic [14:0] a_addr;
    logic [3:0]  b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_busy, b_busy, a_done, b_done, a_err, b_err;
    loader_state_t a_state, b_state;

    uart_loader #(.ADDR_W(15)) dut_a (
        .clk(clk), .rstn(rstn), .start_i(start && !sel), .rx_data_i(rx_data),
        .rx_valid_i(rx_valid && !sel), .rx_ferr_i(rx_ferr && !sel), .tx_busy_i(tx_busy && !sel),
        .tx_data_o(a_tx_data), .tx_start_o(a_tx_start), .imem_we_o(a_we), .imem_addr_o(a_addr),
        .imem_wdata_o(a_wdata), .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .state_o(a_state)
    );

    uart_loader #(.ADDR_W(4)) dut_b (
        .clk(clk), .rstn(rstn), .start_i(start && sel), .rx_data_i(rx_data),
        .rx_valid_i(rx_valid && sel), .rx_ferr_i(rx_ferr && sel), .tx_busy_i(tx_busy && sel),
        .tx_data_o(b_tx_data), .tx_start_o(b_tx_start), .imem_we_o(b_we), .imem_addr_o(b_addr),
        .imem_wdata_o(b_wdata), .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .state_o(b_state)
    );

    logic [7:0]    obs_tx_data;
    logic          obs_tx_start, obs_we, obs_busy, obs_done, obs_err;
    logic [15:0]   obs_addr;
    logic [31:0]   obs_wdata;
    loader_state_t obs_state;

    assign obs_tx_data  = sel ? b_tx_data  : a_tx_data;
    assign obs_tx_start = sel ? b_tx_start : a_tx_start;
    assign obs_we       = sel ? b_we       : a_we;
    assign obs_addr     = sel ? {12'd0, b_addr} : {1'b0, a_addr};
    assign obs_wdata    = sel ? b_wdata    : a_wdata;
    assign obs_busy     = sel ? b_busy     : a_busy;
    assign obs_done     = sel ? b_done     : a_done;
    assign obs_err      = sel ? b_err      : a_err;
    assign obs_state    = sel ? b_state    : a_state;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int tx_cnt = 0;
    logic [47:0] exp_q[$];
    logic [7:0]  exp_tx_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write and every ACK byte must match the queue head.
    always @(negedge clk) begin
        if (rstn && obs_we) begin
            wr_cnt++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%0h_%0h expected=none", obs_addr, obs_wdata);
            end
            if (exp_q.size() > 0) check("imem_write", {obs_addr, obs_wdata}, exp_q.pop_front());
        end
        if (rstn && obs_tx_start) begin
            tx_cnt++;
            check("tx_busy_at_start", tx_busy, 1'b0);
            checks++;
            assert (exp_tx_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_tx observed=%0h expected=none", obs_tx_data);
            end
            if (exp_tx_q.size() > 0) check("tx_data", obs_tx_data, exp_tx_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0; tx_busy = 1'b0;
        tick(3);
        rstn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
        tick(gap);
    endtask

    task automatic load_word(input int addr, input logic [31:0] w, input int gap);
        exp_q.push_back({16'(addr), w});
        send_word(w, gap);
    endtask

    task automatic wait_state(input loader_state_t s, input int budget, input string tag);
        int n = 0;
        while (obs_state != s && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, obs_state, s);
    endtask

    initial begin
        int wr0;
        int tx0;
        logic [31:0] w;

        // Reset values and stray bytes in IDLE
        sel = 1'b0;
        do_reset();
        check("rst_busy", obs_busy, 1'b0);
        check("rst_done", obs_done, 1'b0);
        check("rst_err", obs_err, 1'b0);
        check("rst_we", obs_we, 1'b0);
        check("rst_tx_start", obs_tx_start, 1'b0);
        check("rst_tx_data", obs_tx_data, 8'd0);
        check("rst_addr", obs_addr, 16'd0);
        check("rst_wdata", obs_wdata, 32'd0);
        check("rst_state_a", a_state, ST_IDLE);
        check("rst_state_b", b_state, ST_IDLE);
        send_word(32'h0000_0002, 2);
        check("stray_idle", obs_state, ST_IDLE);
        check("stray_no_write", wr_cnt, 0);

        // Normal load, bytes back to back
        wr0 = wr_cnt; tx0 = tx_cnt;
        pulse_start();
        check("start_len", obs_state, ST_LEN);
        check("start_busy", obs_busy, 1'b1);
        send_word(32'd2, 0);
        load_word(0, 32'h1122_3344, 0);
        load_word(1, 32'hDEAD_BEEF, 0);
        exp_tx_q.push_back(8'hAA);
        wait_state(ST_DONE, 20, "normal_done_state");
        check("normal_done", obs_done, 1'b1);
        check("normal_busy", obs_busy, 1'b0);
        check("normal_writes", wr_cnt - wr0, 2);
        check("normal_tx", tx_cnt - tx0, 1);
        pulse_start();
        check("done_ignores_start", obs_state, ST_DONE);

        // Zero-length load
        do_reset();
        wr0 = wr_cnt; tx0 = tx_cnt;
        pulse_start();
        exp_tx_q.push_back(8'hAA);
        send_word(32'd0, 0);
        wait_state(ST_DONE, 20, "n0_done_state");
        check("n0_done", obs_done, 1'b1);
        check("n0_writes", wr_cnt - wr0, 0);
        check("n0_tx", tx_cnt - tx0, 1);

        // ADDR_W=4: N=17 and N with only upper bits set are rejected
        sel = 1'b1;
        do_reset();
        wr0 = wr_cnt;
        pulse_start();
        send_word(32'd17, 0);
        wait_state(ST_ERR, 5, "n17_err_state");
        check("n17_err", obs_err, 1'b1);
        check("n17_busy", obs_busy, 1'b0);
        send_word(32'h0102_0304, 2);
        check("n17_no_writes", wr_cnt - wr0, 0);
        do_reset();
        pulse_start();
        send_word(32'h0001_0000, 0);
        wait_state(ST_ERR, 5, "nupper_err_state");
        check("nupper_no_writes", wr_cnt - wr0, 0);

        // ADDR_W=4: N=16 fills the memory, addresses 0..15
        do_reset();
        wr0 = wr_cnt; tx0 = tx_cnt;
        pulse_start();
        send_word(32'd16, $urandom_range(0, 2));
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            load_word(i, w, $urandom_range(0, 2));
        end
        exp_tx_q.push_back(8'hAA);
        wait_state(ST_DONE, 30, "n16_done_state");
        check("n16_writes", wr_cnt - wr0, 16);
        check("n16_last_addr", obs_addr, 16'd15);
        check("n16_tx", tx_cnt - tx0, 1);

        // Framing error on the last byte of word 3 discards it
        sel = 1'b0;
        do_reset();
        wr0 = wr_cnt; tx0 = tx_cnt;
        pulse_start();
        send_word(32'd3, 1);
        load_word(0, 32'hCAFE_0001, 1);
        load_word(1, 32'hCAFE_0002, 1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        rx_ferr = 1'b1;
        send_byte(8'h78);
        check("ferr_state", obs_state, ST_ERR);
        check("ferr_err", obs_err, 1'b1);
        tick(2);
        check("ferr_writes", wr_cnt - wr0, 2);
        rx_ferr = 1'b0;
        pulse_start();
        send_word(32'h0000_0001, 0);
        send_word(32'h5555_AAAA, 2);
        check("ferr_sticky", obs_state, ST_ERR);
        check("ferr_no_more_writes", wr_cnt - wr0, 2);
        check("ferr_no_tx", tx_cnt - tx0, 0);

        // Start mid-DATA ignored; ACK held off by tx_busy
        do_reset();
        wr0 = wr_cnt; tx0 = tx_cnt;
        tx_busy = 1'b1;
        pulse_start();
        send_word(32'd3, 0);
        load_word(0, 32'h0BAD_F00D, 0);
        exp_q.push_back({16'd1, 32'h1357_9BDF});
        send_byte(8'h13); send_byte(8'h57);
        pulse_start();
        send_byte(8'h9B); send_byte(8'hDF);
        load_word(2, 32'h2468_ACE0, 0);
        exp_tx_q.push_back(8'hAA);
        wait_state(ST_ACK, 20, "bp_ack_state");
        tick(50);
        check("bp_held_state", obs_state, ST_ACK);
        check("bp_held_busy", obs_busy, 1'b1);
        check("bp_no_tx", tx_cnt - tx0, 0);
        tx_busy = 1'b0;
        tick(1);
        check("bp_tx_start", obs_tx_start, 1'b1);
        tick(1);
        check("bp_tx_pulse", obs_tx_start, 1'b0);
        check("bp_done", obs_done, 1'b1);
        check("bp_writes", wr_cnt - wr0, 3);
        check("bp_tx", tx_cnt - tx0, 1);

        // Reset mid-load returns outputs to reset values
        do_reset();
        pulse_start();
        send_word(32'd2, 0);
        send_byte(8'hEE); send_byte(8'hFF);
        rstn = 1'b0;
        tick(1);
        check("midrst_state", obs_state, ST_IDLE);
        check("midrst_busy", obs_busy, 1'b0);
        rstn = 1'b1;
        tick(2);

        check("exp_q_empty", exp_q.size(), 0);
        check("exp_tx_q_empty", exp_tx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader between `uart_rx` and the core's instruction memory. After a `start` pulse it consumes a byte stream from the receiver: a 4-byte word count N, then N 32-bit words. It writes them to consecutive instruction-memory addresses from 0 and acknowledges the host with one byte through the UART transmitter. The core is held off (`busy`) until `done` is asserted.

## Interface
- `ADDR_W`, 15: instruction-memory word-address width; max loadable N = 2**ADDR_W.
- `ACK_BYTE`, 8'hAA: byte sent to host after the last write.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a load from IDLE.
- `rx_data`  in  8  received byte, valid when `rx_valid`.
- `rx_valid`  in  1  one-cycle pulse per received byte (uart_rx `rdata_ready`).
- `rx_ferr`  in  1  receiver framing error, level, sticky in the receiver.
- `tx_busy`  in  1  transmitter busy.
- `tx_data`  out  8  byte to transmit.
- `tx_start`  out  1  one-cycle transmit request.
- `imem_we`  out  1  write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  word to write.
- `busy`  out  1  high in LEN, DATA, WRITE, ACK.
- `done`  out  1  high in DONE.
- `err`  out  1  high in ERR.

## Operation
- States: IDLE, LEN, DATA, WRITE, ACK, DONE, ERR.
- IDLE: `start`=1 -> LEN. Byte counter, word counter and address are cleared. `rx_valid` in IDLE is ignored.
- LEN: collects 4 bytes, big-endian (first byte = N[31:24]). On the 4th byte:
  - N > 2**ADDR_W -> ERR; no write occurs.
  - N==0 -> ACK.
  - Otherwise -> DATA.
- DATA: collects 4 bytes big-endian into `imem_wdata`. On the 4th byte -> WRITE.
- WRITE (exactly 1 cycle): `imem_we`=1 with `imem_addr` = current index.
  - The index increments after the write.
  - If the written word was number N -> ACK, else -> DATA.
- ACK: waits for `tx_busy`=0, then drives `tx_start`=1 for one cycle with `tx_data`=ACK_BYTE -> DONE.
- DONE: terminal until reset. `start` is ignored.
- ERR: entered from LEN or DATA whenever `rx_ferr`=1. Sticky until reset. No further writes or transmits.
- `start` outside IDLE is ignored.
- An `rx_valid` arriving in the same cycle as `rx_ferr`=1 is discarded; ERR wins.
- Arithmetic:
  - Word counter and N compare are ADDR_W+1 bits wide.
  - The compare is performed on the full 32-bit N; upper bits nonzero => error.
  - For N = 2**ADDR_W, the last address is 2**ADDR_W-1; the address never wraps.
- Reset values: every output 0. `tx_data`=0, `imem_addr`=0, `imem_wdata`=0, state IDLE.

## Timing
- `start` sampled at edge k -> state LEN at k+1. The `busy` register follows in the same cycle.
- The 4th data byte's `rx_valid` at edge k -> `imem_we`=1 during cycle k+1. `imem_wdata` and `imem_addr` are stable in that cycle.
- Minimum spacing between `imem_we` pulses is 4 `rx_valid` pulses. The block must accept an `rx_valid` in the WRITE cycle and count it as byte 0 of the next word.
- ACK entered at k with `tx_busy`=0 -> `tx_start` at k+1 -> `done` at k+2.
- `tx_start` is never asserted while `tx_busy`=1.
- `rstn`=0 mid-load: outputs return to reset values at the next edge. A partial word is discarded.

## Structure
- Package `uart_loader_pkg`:
  - state enum `loader_state_t`.
  - default `ACK_BYTE` constant.
  - `LEN_BYTES`=4 and `WORD_BYTES`=4 constants.
- Sub-module `uart_word_assembler`: 2-bit byte counter plus 32-bit big-endian shift register.
  - Inputs: `clr`, `byte_valid`, `byte_in`.
  - Outputs: `word`, `word_valid` (1-cycle pulse).
  - Shared by the LEN and DATA phases.
- Top level holds the FSM, the word/address counters and the TX handshake.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles -> all outputs 0, state IDLE. Stray `rx_valid` bytes with no `start` -> no `imem_we`.
- Normal load, ADDR_W=15: `start`, then bytes 00 00 00 02 11 22 33 44 DE AD BE EF:
  - writes (addr 0, 0x11223344) and (addr 1, 0xDEADBEEF);
  - then `tx_start` with `tx_data`=0xAA, then `done`=1, `busy`=0.
- N=0: `start`, then 00 00 00 00 -> no `imem_we`, ACK byte 0xAA, `done`=1.
- Oversize, ADDR_W=4: N=17 -> `err`=1, no writes. N=16 -> 16 writes, addresses 0..15, then `done`.
- Framing error: raise `rx_ferr` after 2 of 3 data words -> exactly 2 writes, `err`=1. A later `start` or `rx_valid` has no effect.
- Back-pressure/ignore:
  - hold `tx_busy`=1 for 50 cycles in ACK -> `tx_start` appears 1 cycle after release;
  - pulse `start` mid-DATA -> no restart; addresses continue in sequence.
